adel_run_ctrl: RTL

//  Run controller for the adel core. Owns the instruction memory and the host load port.

---
 rtl/adel_ctrl_pkg.sv | 30 +++
 rtl/adel_imem.sv | 24 ++
 rtl/adel_run_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/adel_ctrl_pkg.sv
// Shared types and constants for the adel run controller.
package adel_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RELEASE,
        S_RUN,
        S_STEP,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        CMD_RUN   = 2'd0,
        CMD_STEP  = 2'd1,
        CMD_STOP  = 2'd2,
        CMD_RESET = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        HC_NONE      = 3'd0,
        HC_STOP      = 3'd1,
        HC_OOB       = 3'd2,
        HC_SELF_LOOP = 3'd3,
        HC_LIMIT     = 3'd4,
        HC_STEP      = 3'd5
    } halt_cause_e;

    localparam logic [15:0] NOP_INST = 16'h8000;

endpackage

// File: rtl/adel_imem.sv
// Instruction memory: synchronous write, asynchronous read, contents not reset.
module adel_imem #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/adel_run_ctrl.sv
// Run controller for the adel core: imem ownership, reset release, run/step
// sequencing, clock gating and halt detection.
module adel_run_ctrl #(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter int unsigned CNT_W      = 32,
    parameter logic [15:0] NOP_INST   = adel_ctrl_pkg::NOP_INST,
    localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [15:0]      host_wdata,
    output logic             host_ready,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cycle_limit,
    input  logic [15:0]      core_pc,
    output logic [15:0]      core_inst,
    output logic             core_nrst,
    output logic             core_clk_en,
    output logic             halted,
    output logic [2:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_count,
    output logic             done,
    output logic             cmd_err
);

    import adel_ctrl_pkg::*;

    state_e            state, state_n;
    halt_cause_e       cause_q, cause_n;
    logic              tgt_step, tgt_step_n;
    logic              err_n, run_clr, limit_ld;
    logic [CNT_W-1:0]  run_count, limit_q;
    logic [15:0]       pc_prev, imem_rdata;
    logic              en_prev;
    cmd_e              op;
    logic              accept, oob, self_loop, limit_hit;

    adel_imem #(.DEPTH(IMEM_DEPTH), .AW(AW)) u_imem (
        .clk   (clk),
        .we    (host_we && host_ready),
        .waddr (host_addr),
        .wdata (host_wdata),
        .raddr (core_pc[AW-1:0]),
        .rdata (imem_rdata)
    );

    assign op         = cmd_e'(cmd_op);
    assign accept     = cmd_valid && cmd_ready;
    assign oob        = core_pc >= 16'(IMEM_DEPTH);
    assign self_loop  = en_prev && (core_pc == pc_prev);
    assign limit_hit  = (limit_q != '0) && (run_count == limit_q);
    assign core_inst  = oob ? NOP_INST : imem_rdata;
    assign host_ready = (state == S_IDLE);
    assign cmd_ready  = (state != S_RELEASE);
    assign halted     = (state == S_HALT);
    assign halt_cause = cause_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        cause_n     = cause_q;
        tgt_step_n  = tgt_step;
        core_clk_en = 1'b0;
        err_n       = 1'b0;
        run_clr     = 1'b0;
        limit_ld    = 1'b0;
        if (accept && op == CMD_RESET) begin
            state_n = S_IDLE;
            cause_n = HC_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == CMD_STOP) begin
                            err_n = 1'b1;
                        end else begin
                            state_n    = S_RELEASE;
                            tgt_step_n = (op == CMD_STEP);
                            run_clr    = (op == CMD_RUN);
                            limit_ld   = (op == CMD_RUN);
                        end
                    end
                end
                S_RELEASE: state_n = tgt_step ? S_STEP : S_RUN;
                S_RUN: begin
                    // Halt sources in priority order; the detecting cycle is not clocked.
                    if (accept && op == CMD_STOP) begin
                        state_n = S_HALT;
                        cause_n = HC_STOP;
                    end else if (oob) begin
                        state_n = S_HALT;
                        cause_n = HC_OOB;
                    end else if (self_loop) begin
                        state_n = S_HALT;
                        cause_n = HC_SELF_LOOP;
                    end else if (limit_hit) begin
                        state_n = S_HALT;
                        cause_n = HC_LIMIT;
                    end else begin
                        core_clk_en = 1'b1;
                    end
                    err_n = accept && (op == CMD_RUN || op == CMD_STEP);
                end
                S_STEP: begin
                    state_n     = S_HALT;
                    cause_n     = oob ? HC_OOB : HC_STEP;
                    core_clk_en = !oob;
                    err_n       = accept;
                end
                S_HALT: begin
                    if (accept) begin
                        case (op)
                            CMD_RUN: begin
                                state_n  = S_RUN;
                                run_clr  = 1'b1;
                                limit_ld = 1'b1;
                            end
                            CMD_STEP: state_n = S_STEP;
                            default:  err_n = 1'b1;
                        endcase
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q     <= HC_NONE;
            tgt_step    <= 1'b0;
            core_nrst   <= 1'b0;
            done        <= 1'b0;
            cmd_err     <= 1'b0;
            en_prev     <= 1'b0;
            pc_prev     <= '0;
            cycle_count <= '0;
            run_count   <= '0;
            limit_q     <= '0;
        end else begin
            cause_q   <= cause_n;
            tgt_step  <= tgt_step_n;
            core_nrst <= (state_n != S_IDLE);
            done      <= (state_n == S_HALT) && (state != S_HALT);
            cmd_err   <= err_n;
            en_prev   <= core_clk_en;
            if (core_clk_en) begin
                pc_prev <= core_pc;
            end
            if (state_n == S_IDLE) begin
                cycle_count <= '0;
            end else if (core_clk_en && cycle_count != '1) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (run_clr) begin
                run_count <= '0;
            end else if (core_clk_en && run_count != '1) begin
                run_count <= run_count + 1'b1;
            end
            if (limit_ld) begin
                limit_q <= cycle_limit;
            end
        end
    end

endmodule
